// File: rtl/normalizer_count.sv
// normalizer_count: iterative CLZ/CTZ normalizer, one bit shifted per cycle.
// Optional zero-operand bypass enabled by macro NORMALIZER_ZERO_SKIP_EN.
module normalizer_count #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Type,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic [5:0]       Cnt,
  output logic [WIDTH-1:0] R
);

  localparam logic [5:0] CNT_MAX = 6'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             type_q, type_d;

  logic accept;
  logic hit;
  logic stop;
  logic shift_en;
  logic zero_op;

  assign accept   = start && (state_q != SHIFT);
  assign hit      = type_q ? r_q[0] : r_q[WIDTH-1];
  assign stop     = hit || (cnt_q == CNT_MAX);
  assign shift_en = (state_q == SHIFT) && !stop;
  assign zero_op  = (A == '0);

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      type_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
    end
  end

  // Next-state: accept from IDLE/DONE, leave SHIFT when the test hits
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
`ifdef NORMALIZER_ZERO_SKIP_EN
          state_d = zero_op ? DONE : SHIFT;
`else
          state_d = SHIFT;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (stop) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, one logical shift per SHIFT miss
  always_comb begin
    r_d    = r_q;
    cnt_d  = cnt_q;
    type_d = type_q;
    unique case (1'b1)
      accept: begin
        r_d    = A;
        cnt_d  = '0;
        type_d = Type;
`ifdef NORMALIZER_ZERO_SKIP_EN
        if (zero_op) begin
          r_d   = '0;
          cnt_d = CNT_MAX;
        end
`endif
      end
      shift_en: begin
        r_d   = type_q ? (r_q >> 1) : (r_q << 1);
        cnt_d = cnt_q + 6'd1;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    Cnt  = cnt_q;
    R    = r_q;
  end

  logic unused_zero;
  assign unused_zero = zero_op;

endmodule

// File: tb/tb_normalizer_count.sv
// tb_normalizer_count: directed self-checking bench for normalizer_count.
// Latency counted in cycles after the start-sampling edge (done at k+N+2 -> 2+N).
module tb_normalizer_count;

  logic        clk;
  logic        rst;
  logic        start;
  logic        Type;
  logic [31:0] A;
  logic        busy;
  logic        done;
  logic [5:0]  Cnt;
  logic [31:0] R;

  int checks;
  int errors;

  normalizer_count #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Type  (Type),
    .A     (A),
    .busy  (busy),
    .done  (done),
    .Cnt   (Cnt),
    .R     (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic t, input logic [31:0] a,
                        output int lat, output int bc,
                        output logic [5:0] c, output logic [31:0] r);
    @(negedge clk);
    start = 1'b1;
    Type  = t;
    A     = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    Type  = ~t;
    A     = $urandom;
    lat   = 1;
    bc    = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for A=%h type=%0d", a, t);
    end
    c = Cnt;
    r = R;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    Type  = 1'b0;
    A     = '0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", done);
    end
    checks++;
    if (Cnt !== 6'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", Cnt);
    end
    checks++;
    if (R !== 32'h0) begin
      errors++; $display("FAIL reset_r: got %h want 0", R);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_op(input string nm, input logic t,
                         input logic [31:0] a, input logic [5:0] ec,
                         input logic [31:0] er, input int el, input int eb);
    int lat, bc;
    logic [5:0] c;
    logic [31:0] r;
    run_op(t, a, lat, bc, c, r);
    checks++;
    if (c !== ec) begin
      errors++; $display("FAIL %s cnt: got %0d want %0d", nm, c, ec);
    end
    checks++;
    if (r !== er) begin
      errors++; $display("FAIL %s r: got %h want %h", nm, r, er);
    end
    checks++;
    if (lat !== el) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, el);
    end
    checks++;
    if (bc !== eb) begin
      errors++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, bc, eb);
    end
  endtask

  task automatic test_clz_ctz();
    test_op("clz_msb", 1'b0, 32'h8000_0000, 6'd0,  32'h8000_0000, 2,  1);
    test_op("clz_lsb", 1'b0, 32'h0000_0001, 6'd31, 32'h8000_0000, 33, 32);
    test_op("ctz_100", 1'b1, 32'h0000_0100, 6'd8,  32'h0000_0001, 10, 9);
    test_op("ctz_msb", 1'b1, 32'h8000_0000, 6'd31, 32'h0000_0001, 33, 32);
    test_op("clz_mid", 1'b0, 32'h0012_3400, 6'd11, 32'h91A0_0000, 13, 12);
    test_op("ctz_lsb", 1'b1, 32'hF000_0001, 6'd0,  32'hF000_0001, 2,  1);
  endtask

  task automatic test_zero();
`ifdef NORMALIZER_ZERO_SKIP_EN
    test_op("zero_clz", 1'b0, 32'h0, 6'd32, 32'h0, 1, 0);
    test_op("zero_ctz", 1'b1, 32'h0, 6'd32, 32'h0, 1, 0);
`else
    test_op("zero_clz", 1'b0, 32'h0, 6'd32, 32'h0, 34, 33);
    test_op("zero_ctz", 1'b1, 32'h0, 6'd32, 32'h0, 34, 33);
`endif
  endtask

  task automatic test_hold();
    test_op("hold_op", 1'b0, 32'h0000_0F00, 6'd20, 32'hF000_0000, 22, 21);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_flags: got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (Cnt !== 6'd20 || R !== 32'hF000_0000) begin
      errors++; $display("FAIL hold_result: got %0d/%h want 20/f0000000", Cnt, R);
    end
  endtask

  task automatic test_busy_start();
    int lat;
    @(negedge clk);
    start = 1'b1; Type = 1'b0; A = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    start = 1'b1; Type = 1'b1; A = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 18) begin
      errors++; $display("FAIL busy_start latency: got %0d want 18", lat);
    end
    checks++;
    if (Cnt !== 6'd16 || R !== 32'hFFFF_0000) begin
      errors++; $display("FAIL busy_start result: got %0d/%h want 16/ffff0000", Cnt, R);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; Type = 1'b0; A = 32'h00F0_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (done !== 1'b1 || Cnt !== 6'd8 || R !== 32'hF000_0000) begin
      errors++; $display("FAIL b2b first: got done=%b %0d/%h want 1 8/f0000000", done, Cnt, R);
    end
    start = 1'b1; Type = 1'b1; A = 32'h0000_0100;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 32'hDEAD_BEEF;
    checks++;
    if (busy !== 1'b1 || Cnt !== 6'd0 || R !== 32'h0000_0100) begin
      errors++; $display("FAIL b2b no_idle: got busy=%b %0d/%h want 1 0/00000100", busy, Cnt, R);
    end
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 10 || Cnt !== 6'd8 || R !== 32'h0000_0001) begin
      errors++; $display("FAIL b2b second: got lat=%0d %0d/%h want 10 8/00000001", lat, Cnt, R);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    start = 1'b1; Type = 1'b0; A = 32'h0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Cnt !== 6'd0 || R !== 32'h0) begin
      errors++; $display("FAIL rst_mid immediate: got b=%b d=%b %0d/%h want 0 0 0/0", busy, done, Cnt, R);
    end
    start = 1'b1; A = 32'h1234_5678;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || R !== 32'h0) begin
      errors++; $display("FAIL rst_start_ignored: got busy=%b r=%h want 0 0", busy, R);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL rst_abort: got %0d active cycles want 0", pulses);
    end
    test_op("after_rst", 1'b0, 32'h4000_0000, 6'd1, 32'h8000_0000, 3, 2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clz_ctz();
    test_zero();
    test_hold();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/normalizer_count.md
NORMALIZER_COUNT -- requirements
Module: normalizer_count

Interface
REQ-001 Parameter WIDTH, default 32, data width; the count width CW is fixed at 6 bits, covering results 0..32.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset, asynchronous and active-high.
REQ-004 start  input  1  Request to begin an operation; sampled on the rising edge of clk.
REQ-005 Type  input  1  0 = count leading zeros (left-normalize); 1 = count trailing zeros (right-normalize).
REQ-006 A  input  32  Operand; captured only in the cycle start is accepted.
REQ-007 busy  output  1  High while the operation is in SHIFT.
REQ-008 done  output  1  One-cycle pulse; R and Cnt are valid in this cycle.
REQ-009 Cnt  output  6  Number of zero bits counted, 0..32.
REQ-010 R  output  32  Normalized operand.
- CLZ (Type=0): A shifted left by Cnt.
- CTZ (Type=1): A logically shifted right by Cnt.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 start SHALL be accepted in IDLE or DONE; on acceptance the block captures A into R, Type into an internal register, clears Cnt to 0 and moves to SHIFT.
REQ-013 start in SHIFT SHALL be ignored, with no effect on R, Cnt or the stored Type.
REQ-014 Each SHIFT cycle tests one condition: for CLZ, R[31]==1; for CTZ, R[0]==1; or Cnt==32.
- Test true: the next state is DONE and R and Cnt hold.
- Test false: R shifts by one (zero fill), Cnt increments by 1, and the FSM stays in SHIFT.
REQ-015 Shifting SHALL be logical in both directions; no sign fill.
REQ-016 done SHALL be 1 only in DONE, and DONE SHALL last exactly one cycle.
REQ-017 After DONE the FSM SHALL go to IDLE, or to SHIFT if start is high in that cycle.
REQ-018 busy SHALL be 1 only in SHIFT.
REQ-019 Latency: start sampled in cycle k with result count N SHALL give done in cycle k+N+2.
REQ-020 Zero operand SHALL finish with Cnt=32 and R=0; done in cycle k+34 (macro off).
REQ-021 R and Cnt SHALL hold their last result in IDLE until the next accepted start.
REQ-022 Cnt SHALL never exceed 32; no wrap-around.

Reset
REQ-023 rst high SHALL immediately force the following, regardless of clk:
- state=IDLE
- R=0, Cnt=0, busy=0, done=0
- stored Type=0
REQ-024 rst asserted during SHIFT SHALL abort the operation; no done pulse follows.
REQ-025 While rst is high, start SHALL be ignored.
REQ-026 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro NORMALIZER_ZERO_SKIP_EN SHALL enable zero-operand bypass; with the macro undefined, zero operands take the full 32-shift path per REQ-020.
REQ-028 With NORMALIZER_ZERO_SKIP_EN defined, accepting start with A==0 SHALL load Cnt=32 and R=0 and go directly to DONE.
- done is high in cycle k+1.
- busy is never asserted for that operation.
REQ-029 The macro SHALL NOT change results or latency for any nonzero A.

Verification
REQ-030 CLZ, A=0x8000_0000 -> Cnt=0, R=0x8000_0000, done in k+2, busy high for 1 cycle.
REQ-031 CLZ, A=0x0000_0001 -> Cnt=31, R=0x8000_0000, done in k+33; CTZ, A=0x0000_0100 -> Cnt=8, R=0x0000_0001, done in k+10.
REQ-032 Zero operand, A=0x0000_0000 (either Type) -> Cnt=32, R=0.
- Macro off: done in k+34.
- Macro on: done in k+1, busy never high.
REQ-033 Busy-start and back-to-back:
- start pulsed with A=0xFFFF_FFFF while busy on a CLZ of 0x0000_FFFF -> result Cnt=16, R=0xFFFF_0000, unaffected.
- start held high during DONE -> new operation begins without an IDLE cycle.
REQ-034 Reset mid-operation: rst asserted mid-edge during SHIFT of a CLZ of 0x0000_0001 -> outputs 0 immediately, no done.
- The next start with A=0x4000_0000, CLZ -> Cnt=1, R=0x8000_0000.
